mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning Busy duration in cycles for MULT/MULTU; legal range 1..31.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning Busy duration in cycles for DIV/DIVU; legal range 1..31.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Start, input, 1 bit: single-cycle request strobe, sampled on the rising edge of clk.
REQ-006 SHALL have port Op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; codes 6 and 7 are no-ops.
REQ-007 SHALL have port A, input, 32 bits: rs operand; the multiplicand or dividend, or the MTHI/MTLO data.
REQ-008 SHALL have port B, input, 32 bits: rt operand; the multiplier or divisor.
REQ-009 SHALL have port Busy, output, 1 bit: registered; high while an operation is in flight.
REQ-010 SHALL have port HI, output, 32 bits: registered architectural HI, read by the mfhi path toward the register-file write data.
REQ-011 SHALL have port LO, output, 32 bits: registered architectural LO, read by the mflo path.

Function
REQ-012 A request SHALL be accepted at a rising edge only when Start=1, Busy=0 and Reset=0.
REQ-013 Start asserted while Busy=1 SHALL be ignored, with no change to state, HI, LO or Busy.
REQ-014 Accepted MULT SHALL capture the signed 64-bit product A*B, with HI = product[63:32] and LO = product[31:0].
REQ-015 Accepted MULTU SHALL capture the same split as MULT, computed on the unsigned product.
REQ-016 Accepted DIV SHALL capture signed results: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
REQ-017 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000, with no error signalled.
REQ-018 Accepted DIVU SHALL capture the unsigned quotient into LO and the unsigned remainder into HI.
REQ-019 For DIV/DIVU with B=0, HI and LO SHALL stay unchanged at completion, while Busy still runs for the full DIV_CYCLES.
REQ-020 Operands and Op SHALL be latched at acceptance, so A, B and Op changing afterwards SHALL have no effect on the result.
REQ-021 The block SHALL have two states, IDLE (Busy=0) and RUN (Busy=1), plus an internal down-counter of 5 bits.
REQ-022 IDLE->RUN SHALL occur on accepting MULT/MULTU/DIV/DIVU, loading the counter with MULT_CYCLES or DIV_CYCLES.
REQ-023 In RUN the counter SHALL decrement once per edge.
REQ-024 RUN->IDLE SHALL occur at the edge where the counter is 1; HI and LO SHALL update at that same edge.
REQ-025 Given acceptance at edge k, Busy SHALL be 1 for exactly the N cycles between edge k and edge k+N, and the results SHALL be visible after edge k+N.
REQ-026 HI and LO SHALL hold their previous values throughout RUN; no partial results SHALL be visible.
REQ-027 Accepted MTHI SHALL set HI<=A at the accepting edge; LO SHALL be unchanged and Busy SHALL stay 0.
REQ-028 Accepted MTLO SHALL set LO<=A at the accepting edge; HI SHALL be unchanged and Busy SHALL stay 0.
REQ-029 Accepted Op 6 or 7 SHALL change nothing.
REQ-030 A new request SHALL be accepted at the edge immediately following the edge on which Busy falls, giving back-to-back operations with no dead cycle.
REQ-031 Internally the block SHALL precompute the result at acceptance into hidden pending registers; any multi-cycle datapath meeting REQ-024..026 is equally acceptable.

Reset
REQ-032 Reset=1 at a rising edge SHALL force HI=0, LO=0, Busy=0, the state to IDLE, and the counter and pending registers to 0.
REQ-033 Reset SHALL take priority over Start in the same cycle; the request SHALL be discarded.
REQ-034 Reset during RUN SHALL cancel the in-flight operation; its result SHALL never reach HI or LO.
REQ-035 After Reset deasserts, the first edge with Start=1 SHALL be accepted normally.

Verification
REQ-036 MULT, A=0xFFFFFFFE (-2), B=0x00000003 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-037 MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
REQ-038 DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles; also check DIV of 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 After MTHI A=0x12345678 and MTLO A=0x9ABCDEF0, run DIVU with B=0 -> Busy for 10 cycles, then HI=0x12345678, LO=0x9ABCDEF0 unchanged.
REQ-040 Start DIVU A=100, B=7, pulse Start MULT mid-RUN, then Reset at cycle 4 -> the MULT is ignored, HI=LO=0 and Busy=0 at the next edge, and the DIVU result never appears.
REQ-041 MULTU A=3, B=4 immediately followed by DIVU A=9, B=2 on the edge after Busy falls -> LO=12, then LO=4 and HI=1; Busy low for exactly 1 cycle between the two operations.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit holding architectural HI/LO. Results are precomputed at
// acceptance into pending registers and committed when the busy countdown ends.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_e;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        pend_wr_q;

    logic [31:0] pend_hi_d, pend_lo_d;
    logic        pend_wr_d;
    logic        launch_d;
    logic [4:0]  cnt_d;

    logic [63:0] prod_s, prod_u;
    logic        neg_q, neg_r;
    logic [31:0] num, den, den_safe, q_mag, r_mag;

    // One shared divider: signed DIV works on magnitudes and fixes signs after.
    // |0x80000000| stays 0x80000000 as unsigned, so INT_MIN / -1 yields 0x80000000 naturally.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        if (op_e'(Op) == OP_DIV) begin
            num   = A[31] ? (32'd0 - A) : A;
            den   = B[31] ? (32'd0 - B) : B;
            neg_q = A[31] ^ B[31];
            neg_r = A[31];
        end else begin
            num   = A;
            den   = B;
            neg_q = 1'b0;
            neg_r = 1'b0;
        end
        den_safe = (den == '0) ? 32'd1 : den;
        q_mag    = num / den_safe;
        r_mag    = num % den_safe;

        pend_hi_d = '0;
        pend_lo_d = '0;
        pend_wr_d = 1'b0;
        launch_d  = 1'b0;
        cnt_d     = '0;
        case (op_e'(Op))
            OP_MULT: begin
                {pend_hi_d, pend_lo_d} = prod_s;
                pend_wr_d = 1'b1;
                launch_d  = 1'b1;
                cnt_d     = 5'(MULT_CYCLES);
            end
            OP_MULTU: begin
                {pend_hi_d, pend_lo_d} = prod_u;
                pend_wr_d = 1'b1;
                launch_d  = 1'b1;
                cnt_d     = 5'(MULT_CYCLES);
            end
            OP_DIV, OP_DIVU: begin
                pend_lo_d = neg_q ? (32'd0 - q_mag) : q_mag;
                pend_hi_d = neg_r ? (32'd0 - r_mag) : r_mag;
                pend_wr_d = (B != '0);
                launch_d  = 1'b1;
                cnt_d     = 5'(DIV_CYCLES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (launch_d) begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            cnt_q     <= cnt_d;
                            pend_hi_q <= pend_hi_d;
                            pend_lo_q <= pend_lo_d;
                            pend_wr_q <= pend_wr_d;
                        end else if (op_e'(Op) == OP_MTHI) begin
                            hi_q <= A;
                        end else if (op_e'(Op) == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
